// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned CntW          = 6;
   localparam int unsigned RegW          = 5;
   localparam int unsigned PerfW         = 32;
   localparam int unsigned MultCyclesDef = 4;
   localparam int unsigned DivCyclesDef  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      LAST = 2'd2
   } mdState_e;

endpackage

// File: rtl/hazard_if.sv
// Hazard controller bundle: ID/EX/MEM observation inputs and pipeline control outputs.
interface hazard_if;
   import hazard_pkg::*;

   logic [RegW-1:0] Rs_ID;
   logic [RegW-1:0] Rt_ID;
   logic            UseRs_ID;
   logic            UseRt_ID;
   logic            Jr_ID;
   logic            Taken_ID;
   logic            HiLoUse_ID;
   logic [RegW-1:0] RegAddr_EX;
   logic [RegW-1:0] RegAddr_MEM;
   logic            MemRead_EX;
   logic            MemRead_MEM;
   logic            MulDivStart_EX;
   logic            IsDiv_EX;

   logic            StallPC;
   logic            StallIFID;
   logic            BubbleIDEX;
   logic            FlushIFID;
   logic            MulDivBusy;
   logic            MulDivDone;

   // Pipeline side: drives stage information, consumes the controls.
   modport master (
      output Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, Jr_ID, Taken_ID, HiLoUse_ID,
             RegAddr_EX, RegAddr_MEM, MemRead_EX, MemRead_MEM,
             MulDivStart_EX, IsDiv_EX,
      input  StallPC, StallIFID, BubbleIDEX, FlushIFID, MulDivBusy, MulDivDone
   );

   // Hazard controller side.
   modport slave (
      input  Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, Jr_ID, Taken_ID, HiLoUse_ID,
             RegAddr_EX, RegAddr_MEM, MemRead_EX, MemRead_MEM,
             MulDivStart_EX, IsDiv_EX,
      output StallPC, StallIFID, BubbleIDEX, FlushIFID, MulDivBusy, MulDivDone
   );

endinterface

// File: rtl/muldiv_busy_timer.sv
// HI/LO unit occupancy tracker: IDLE -> BUSY (counting) -> LAST, with registered Busy/Done.
module muldiv_busy_timer
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MultCyclesDef,
   parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     MulDivStart_EX,
   input  logic     IsDiv_EX,
   output logic     MulDivBusy,
   output logic     MulDivDone,
   output mdState_e state
);

   logic [CntW-1:0] cnt;
   logic [CntW-1:0] loadVal;

   // Remaining BUSY cycles for the operation entering EX; zero means straight to LAST.
   assign loadVal = IsDiv_EX ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);

   // State, counter and registered status flags advance together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         MulDivBusy <= 1'b0;
         MulDivDone <= 1'b0;
      end else begin
         case (state)
            IDLE, LAST: begin
               if (MulDivStart_EX) begin
                  cnt        <= loadVal;
                  MulDivBusy <= 1'b1;
                  if (loadVal == '0) begin
                     state      <= LAST;
                     MulDivDone <= 1'b1;
                  end else begin
                     state      <= BUSY;
                     MulDivDone <= 1'b0;
                  end
               end else begin
                  state      <= IDLE;
                  MulDivBusy <= 1'b0;
                  MulDivDone <= 1'b0;
               end
            end
            BUSY: begin
               MulDivBusy <= 1'b1;
               if (cnt != '0) cnt <= cnt - CntW'(1);
               if (cnt == CntW'(1)) begin
                  state      <= LAST;
                  MulDivDone <= 1'b1;
               end else begin
                  MulDivDone <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               MulDivBusy <= 1'b0;
               MulDivDone <= 1'b0;
            end
         endcase
      end
   end

   // Flag unreachable situations: decrement at zero, and a new issue while BUSY (MdHaz should prevent it).
   always @(posedge clk) begin
      if (rst_n && state == BUSY) begin
         assert (cnt != '0);
         assert (!MulDivStart_EX);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, jr operand and HI/LO interlock stalls plus IF/ID flush.
// Optional build macro HAZARD_PERF_CNT_EN adds per-term 32-bit event counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MultCyclesDef,
   parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_if.slave          hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PerfW-1:0] LoadStallCnt,
   output logic [PerfW-1:0] JrStallCnt,
   output logic [PerfW-1:0] MdStallCnt,
   output logic [PerfW-1:0] FlushCnt
`endif
);

   mdState_e mdState;
   logic     mdBusy;
   logic     mdDone;
   logic     loadUse;
   logic     jrHaz;
   logic     mdHaz;
   logic     stall;
   logic     flush;

   muldiv_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) uTimer (
      .clk            (clk),
      .rst_n          (rst_n),
      .MulDivStart_EX (hz.MulDivStart_EX),
      .IsDiv_EX       (hz.IsDiv_EX),
      .MulDivBusy     (mdBusy),
      .MulDivDone     (mdDone),
      .state          (mdState)
   );

   // Hazard terms; all controls are held low while in reset.
   always_comb begin
      loadUse = 1'b0;
      jrHaz   = 1'b0;
      mdHaz   = 1'b0;
      if (rst_n) begin
         loadUse = hz.MemRead_EX && (hz.RegAddr_EX != '0) &&
                   ((hz.UseRs_ID && (hz.RegAddr_EX == hz.Rs_ID)) ||
                    (hz.UseRt_ID && (hz.RegAddr_EX == hz.Rt_ID)));
         jrHaz   = hz.Jr_ID && (hz.Rs_ID != '0) &&
                   ((hz.MemRead_EX  && (hz.RegAddr_EX  == hz.Rs_ID)) ||
                    (hz.MemRead_MEM && (hz.RegAddr_MEM == hz.Rs_ID)));
         mdHaz   = hz.HiLoUse_ID && (mdState == BUSY);
      end
   end

   assign stall = loadUse | jrHaz | mdHaz;
   assign flush = rst_n && hz.Taken_ID && !stall;

   assign hz.StallPC    = stall;
   assign hz.StallIFID  = stall;
   assign hz.BubbleIDEX = stall;
   assign hz.FlushIFID  = flush;
   assign hz.MulDivBusy = mdBusy;
   assign hz.MulDivDone = mdDone;

`ifdef HAZARD_PERF_CNT_EN
   // Per-term event counters, free-running modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LoadStallCnt <= '0;
         JrStallCnt   <= '0;
         MdStallCnt   <= '0;
         FlushCnt     <= '0;
      end else begin
         if (loadUse) LoadStallCnt <= LoadStallCnt + PerfW'(1);
         if (jrHaz)   JrStallCnt   <= JrStallCnt   + PerfW'(1);
         if (mdHaz)   MdStallCnt   <= MdStallCnt   + PerfW'(1);
         if (flush)   FlushCnt     <= FlushCnt     + PerfW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps followed by random traffic,
// all compared against a cycle-level reference model.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int unsigned MulLat = 4;
   localparam int unsigned DivLat = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_if hz ();

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] loadCnt, jrCnt, mdCnt, flushCnt;
   logic [31:0] mLoad, mJr, mMd, mFlush;
`endif

   hazard_ctrl #(
      .MULT_CYCLES (MulLat),
      .DIV_CYCLES  (DivLat)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .LoadStallCnt (loadCnt),
      .JrStallCnt   (jrCnt),
      .MdStallCnt   (mdCnt),
      .FlushCnt     (flushCnt)
`endif
   );

   int   nCmp  = 0;
   int   nFail = 0;
   int   busyLeft = 0;   // model: busy cycles still to come, including the current one
   logic obsStall, obsFlush, obsBusy, obsDone;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hz.Rs_ID = '0; hz.Rt_ID = '0; hz.UseRs_ID = 0; hz.UseRt_ID = 0;
      hz.Jr_ID = 0; hz.Taken_ID = 0; hz.HiLoUse_ID = 0;
      hz.RegAddr_EX = '0; hz.RegAddr_MEM = '0;
      hz.MemRead_EX = 0; hz.MemRead_MEM = 0;
      hz.MulDivStart_EX = 0; hz.IsDiv_EX = 0;
   endtask

   // One pipeline cycle: inputs already applied after a negedge; check, then cross the edge.
   task automatic cyc(input string tag);
      logic eLu, eJr, eMd, eStall, eFlush, eBusy, eDone;
      #1;
      eLu = 0; eJr = 0; eMd = 0; eBusy = 0; eDone = 0;
      if (rst_n) begin
         eLu = hz.MemRead_EX && hz.RegAddr_EX != 0 &&
               ((hz.UseRs_ID && hz.RegAddr_EX == hz.Rs_ID) ||
                (hz.UseRt_ID && hz.RegAddr_EX == hz.Rt_ID));
         eJr = hz.Jr_ID && hz.Rs_ID != 0 &&
               ((hz.MemRead_EX && hz.RegAddr_EX == hz.Rs_ID) ||
                (hz.MemRead_MEM && hz.RegAddr_MEM == hz.Rs_ID));
         eMd   = hz.HiLoUse_ID && busyLeft > 1;
         eBusy = busyLeft > 0;
         eDone = busyLeft == 1;
      end
      eStall = eLu | eJr | eMd;
      eFlush = rst_n && hz.Taken_ID && !eStall;
      obsStall = hz.StallPC; obsFlush = hz.FlushIFID;
      obsBusy  = hz.MulDivBusy; obsDone = hz.MulDivDone;
      chk({tag, ".StallPC"},    hz.StallPC,    eStall);
      chk({tag, ".StallIFID"},  hz.StallIFID,  eStall);
      chk({tag, ".BubbleIDEX"}, hz.BubbleIDEX, eStall);
      chk({tag, ".FlushIFID"},  hz.FlushIFID,  eFlush);
      chk({tag, ".MulDivBusy"}, hz.MulDivBusy, eBusy);
      chk({tag, ".MulDivDone"}, hz.MulDivDone, eDone);
      @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
      if (!rst_n) begin
         mLoad = 0; mJr = 0; mMd = 0; mFlush = 0;
      end else begin
         mLoad  += 32'(eLu);
         mJr    += 32'(eJr);
         mMd    += 32'(eMd);
         mFlush += 32'(eFlush);
      end
`endif
      if (!rst_n) busyLeft = 0;
      else if (hz.MulDivStart_EX && busyLeft <= 1) busyLeft = hz.IsDiv_EX ? DivLat : MulLat;
      else if (busyLeft > 0) busyLeft--;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n, nb, nd;
`ifdef HAZARD_PERF_CNT_EN
      mLoad = 0; mJr = 0; mMd = 0; mFlush = 0;
`endif
      // Reset with hazard-looking inputs present: everything must stay low.
      idle();
      rst_n = 0;
      hz.MemRead_EX = 1; hz.RegAddr_EX = 5'd3; hz.Rs_ID = 5'd3; hz.UseRs_ID = 1; hz.Taken_ID = 1;
      @(negedge clk);
      cyc("rst0");
      cyc("rst1");
      rst_n = 1;
      idle();
      cyc("postRst");

      // lw $3 in EX, add reading $3 in ID: one bubble.
      hz.MemRead_EX = 1; hz.RegAddr_EX = 5'd3; hz.Rt_ID = 5'd3; hz.UseRt_ID = 1;
      cyc("lu");
      chk("lu.stall", 32'(obsStall), 1);
      hz.MemRead_EX = 0; hz.RegAddr_EX = '0; hz.MemRead_MEM = 1; hz.RegAddr_MEM = 5'd3;
      cyc("luRel");
      chk("lu.release", 32'(obsStall), 0);
      // Load targeting $0 never stalls.
      idle();
      hz.MemRead_EX = 1; hz.RegAddr_EX = '0; hz.Rs_ID = '0; hz.UseRs_ID = 1;
      cyc("luZero");
      chk("lu.zeroReg", 32'(obsStall), 0);

      // lw $5 then jr $5: two stall cycles.
      idle();
      n = 0;
      hz.Jr_ID = 1; hz.Rs_ID = 5'd5; hz.UseRs_ID = 1; hz.MemRead_EX = 1; hz.RegAddr_EX = 5'd5;
      cyc("jr1"); n += int'(obsStall);
      hz.MemRead_EX = 0; hz.RegAddr_EX = '0; hz.MemRead_MEM = 1; hz.RegAddr_MEM = 5'd5;
      cyc("jr2"); n += int'(obsStall);
      hz.MemRead_MEM = 0; hz.RegAddr_MEM = '0;
      cyc("jr3"); n += int'(obsStall);
      chk("jr.loadStalls", 32'(n), 2);
      // add $5 then jr $5: forwarded, no stall.
      hz.RegAddr_EX = 5'd5;
      cyc("jrAlu");
      chk("jr.aluNoStall", 32'(obsStall), 0);

      // Taken branch, no hazard: single flush.
      idle();
      hz.Taken_ID = 1;
      cyc("br");
      chk("br.flush", 32'(obsFlush), 1);
      hz.Taken_ID = 0;
      cyc("brNext");
      chk("br.flushOff", 32'(obsFlush), 0);
      // Taken with load-use: stall wins, flush next cycle.
      hz.Taken_ID = 1; hz.MemRead_EX = 1; hz.RegAddr_EX = 5'd7; hz.Rs_ID = 5'd7; hz.UseRs_ID = 1;
      cyc("brLu");
      chk("brLu.noFlush", 32'(obsFlush), 0);
      hz.MemRead_EX = 0; hz.RegAddr_EX = '0;
      cyc("brLu2");
      chk("brLu.flushAfter", 32'(obsFlush), 1);

      // Multiply then dependent mflo.
      idle();
      hz.MulDivStart_EX = 1; hz.IsDiv_EX = 0;
      cyc("mulIssue");
      hz.MulDivStart_EX = 0; hz.HiLoUse_ID = 1;
      n = 0; nb = 0; nd = 0;
      for (int i = 0; i < 100; i++) begin
         cyc("mul");
         nb += int'(obsBusy); nd += int'(obsDone);
         if (!obsStall) break;
         n++;
      end
      hz.HiLoUse_ID = 0;
      for (int i = 0; i < 10; i++) begin
         cyc("mulTail");
         if (!obsBusy) break;
         nb++; nd += int'(obsDone);
      end
      chk("mul.stalls", 32'(n), 3);
      chk("mul.busyCycles", 32'(nb), 4);
      chk("mul.donePulses", 32'(nd), 1);

      // Divide then dependent mfhi.
      hz.MulDivStart_EX = 1; hz.IsDiv_EX = 1;
      cyc("divIssue");
      hz.MulDivStart_EX = 0; hz.IsDiv_EX = 0; hz.HiLoUse_ID = 1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         cyc("div");
         if (!obsStall) break;
         n++;
      end
      chk("div.stalls", 32'(n), 31);
      idle();
      cyc("divTail");

      // Reset in the middle of a divide: immediate abort, no Done.
      hz.MulDivStart_EX = 1; hz.IsDiv_EX = 1;
      cyc("abortIssue");
      idle();
      for (int i = 0; i < 9; i++) cyc("abortRun");
      rst_n = 0;
      hz.HiLoUse_ID = 1;
      cyc("abortRst");
      chk("abort.busyLow", 32'(obsBusy), 0);
      cyc("abortRst2");
      rst_n = 1;
      nd = 0;
      for (int i = 0; i < 30; i++) begin
         cyc("abortAfter");
         nd += int'(obsDone);
         if (i == 0) chk("abort.mfhiNoStall", 32'(obsStall), 0);
      end
      chk("abort.noDone", 32'(nd), 0);

      // Random traffic against the model; issues only when the unit can accept.
      idle();
      for (int i = 0; i < 500; i++) begin
         hz.Rs_ID       = 5'($urandom_range(0, 3));
         hz.Rt_ID       = 5'($urandom_range(0, 3));
         hz.UseRs_ID    = 1'($urandom_range(0, 1));
         hz.UseRt_ID    = 1'($urandom_range(0, 1));
         hz.Jr_ID       = ($urandom_range(0, 3) == 0);
         hz.Taken_ID    = ($urandom_range(0, 3) == 0);
         hz.HiLoUse_ID  = ($urandom_range(0, 2) == 0);
         hz.RegAddr_EX  = 5'($urandom_range(0, 3));
         hz.RegAddr_MEM = 5'($urandom_range(0, 3));
         hz.MemRead_EX  = 1'($urandom_range(0, 1));
         hz.MemRead_MEM = 1'($urandom_range(0, 1));
         hz.MulDivStart_EX = (busyLeft <= 1) && ($urandom_range(0, 5) == 0);
         hz.IsDiv_EX    = ($urandom_range(0, 3) == 0);
         cyc("rnd");
      end
      idle();
      cyc("end");

`ifdef HAZARD_PERF_CNT_EN
      chk("perf.LoadStallCnt", loadCnt,  mLoad);
      chk("perf.JrStallCnt",   jrCnt,    mJr);
      chk("perf.MdStallCnt",   mdCnt,    mMd);
      chk("perf.FlushCnt",     flushCnt, mFlush);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the forwarding unit and covers every hazard that forwarding cannot resolve:
- load-use stalls;
- jr/jalr operand stalls;
- multiply/divide busy interlock, sequenced by an internal FSM and cycle counter;
- IF/ID flush on taken branches and jumps resolved in ID.

It drives the PC, IF/ID and ID/EX pipeline-register hold, bubble and flush controls.

## Interface
Parameters:
- MULT_CYCLES, 4, EX-side latency of mult/multu, range 1..63
- DIV_CYCLES, 32, EX-side latency of div/divu, range 1..63

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- Rs_ID, Rt_ID  in  5 each  source registers of the instruction in ID
- UseRs_ID, UseRt_ID  in  1 each  ID instruction actually reads Rs / Rt
- Jr_ID  in  1  ID instruction is jr/jalr, which reads Rs in ID
- Taken_ID  in  1  branch/jump resolved taken in ID
- HiLoUse_ID  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- RegAddr_EX, RegAddr_MEM  in  5 each  destination registers
- MemRead_EX, MemRead_MEM  in  1 each  load in EX / MEM
- MulDivStart_EX  in  1  mult/div entering EX this cycle
- IsDiv_EX  in  1  1 = divide, 0 = multiply
- StallPC, StallIFID  out  1 each  hold the PC / hold IF/ID
- BubbleIDEX  out  1  load NOP into ID/EX
- FlushIFID  out  1  load NOP into IF/ID
- MulDivBusy  out  1  HI/LO unit busy (registered)
- MulDivDone  out  1  one-cycle pulse on the last busy cycle (registered)

## Operation
Reset behaviour:
- While rst_n is low, all outputs are 0, the FSM is in IDLE and the counter is 0.

Stall sources (hazard terms). Each term is combinational and requires the named register ≠ 0.
- LoadUse = MemRead_EX && RegAddr_EX == (Rs_ID & UseRs_ID, or Rt_ID & UseRt_ID).
- JrHaz = Jr_ID && ((MemRead_EX && RegAddr_EX == Rs_ID) || (MemRead_MEM && RegAddr_MEM == Rs_ID)).
  - A non-load result in EX/MEM is forwarded and does not stall.
- MdHaz = HiLoUse_ID && (state == BUSY).

Stall and flush outputs:
- Stall = LoadUse | JrHaz | MdHaz.
- Stall asserts StallPC, StallIFID and BubbleIDEX together.
- FlushIFID = Taken_ID && !Stall. Stall has priority; the branch is re-evaluated the cycle after the stall releases.

FSM states:
- IDLE
  - MulDivStart_EX → BUSY.
  - cnt loads (IsDiv_EX ? DIV_CYCLES : MULT_CYCLES) − 1.
- BUSY
  - cnt decrements each cycle.
  - When cnt == 1 → LAST.
  - If the loaded value is 0 (latency 1), the FSM goes directly IDLE → LAST.
- LAST
  - MulDivDone = 1 and MulDivBusy = 1.
  - MdHaz does not fire here: HI/LO is written at the end of LAST, and the unit forwards it.
  - Next state is IDLE, or BUSY if MulDivStart_EX is set (back-to-back issue).

Counter:
- cnt is 6 bits, unsigned, with no wrap.
- A decrement at 0 is unreachable; an assertion must flag it.
- A MulDivStart_EX while in BUSY is impossible because MdHaz stalls it. That start is ignored and flagged by an assertion.

Mid-operation reset:
- Asserting rst_n low mid-BUSY aborts immediately.
- MulDivDone never pulses for the aborted operation.

## Timing
- Stall/flush outputs: zero-latency combinational from inputs and the registered state.
- MulDivBusy/MulDivDone are registered and change only on clk rising edges (or on async reset).
- Load-use costs exactly 1 bubble.
- jr behind a load costs 2 stall cycles when the load is in EX, 1 cycle when it is in MEM.
- Multiply issued at edge t (MULT_CYCLES = 4):
  - MulDivBusy is high for cycles t+1..t+4.
  - MulDivDone is high in cycle t+4.
  - A dependent mfhi in ID stalls through cycles t+1..t+3 and advances in t+4.
- Simultaneous LoadUse and Taken_ID: stall only; flush occurs in the following cycle if Taken_ID still holds.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds output ports LoadStallCnt, JrStallCnt, MdStallCnt, FlushCnt, each 32 bits.
  - Each counter is reset to 0 and increments once per cycle its source term asserts.
  - When several terms are active in one cycle, each increments.
  - Counters wrap modulo 2^32.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

## Structure
- Shared package hazard_pkg holds:
  - the FSM state enum (IDLE, BUSY, LAST);
  - default MULT_CYCLES/DIV_CYCLES constants;
  - the counter width constant (6).
- Sub-module muldiv_busy_timer holds the FSM and counter, with outputs MulDivBusy, MulDivDone and state.
- The top level keeps the combinational hazard terms and the optional perf counters.

## Test plan
- lw $3 in EX, add reading $3 in ID → StallPC = StallIFID = BubbleIDEX = 1 for exactly 1 cycle; with RegAddr_EX = 0 → no stall.
- lw $5 followed by jr $5 → 2 stall cycles, then 0; add $5 followed by jr $5 → no stall.
- mult issued, MULT_CYCLES = 4, mflo in ID next → Busy for 4 cycles, Done on the 4th, stall for 3 cycles; div with DIV_CYCLES = 32 → stall for 31 cycles.
- Taken_ID with no hazard → FlushIFID = 1 for 1 cycle; Taken_ID together with LoadUse → FlushIFID = 0, then 1 on the next cycle.
- rst_n low at cycle 10 of a div → outputs 0 immediately, state IDLE, no Done pulse; after release an mfhi does not stall.
- With HAZARD_PERF_CNT_EN: 3 load-use events and 2 flushes → LoadStallCnt = 3, FlushCnt = 2; preload near 2^32−1 → counter wraps to 0.
